stopwatch_ctrl: RTL

Sequencer for the lab stopwatch datapath. It takes one-cycle button pulses (start/stop, lap, clear) and a count-rate tick, runs a four-state control FSM, and owns the mm:ss BCD count chain and the lap-hold register. Upstream blocks (debounce/one-pulse and the clock divider) feed it. Downstream, its BCD output drives the seven-segment scan block directly.

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/stopwatch_if.sv | 39 +++
 rtl/stopwatch_bcd_digit_cnt.sv | 33 +++
 rtl/stopwatch_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch control slice.
// State encodings, BCD digit maxima and a small state helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } sw_state_e;

    localparam int SEC_ONES_MAX = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_ONES_MAX = 9;
    localparam int MIN_TENS_MAX = 5;

    // The count chain advances only while the watch is live.
    function automatic logic is_counting(sw_state_e s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Button/tick inputs and display/status outputs of the stopwatch.
// Master drives pulses and tick; slave is the controller.
interface stopwatch_if;

    logic        tick;
    logic        start_pulse;
    logic        lap_pulse;
    logic        clear_pulse;
    logic [15:0] disp_bcd;
    logic [1:0]  state;
    logic        running;
    logic        frozen;
    logic        wrap_pulse;

    modport master (
        output tick,
        output start_pulse,
        output lap_pulse,
        output clear_pulse,
        input  disp_bcd,
        input  state,
        input  running,
        input  frozen,
        input  wrap_pulse
    );

    modport slave (
        input  tick,
        input  start_pulse,
        input  lap_pulse,
        input  clear_pulse,
        output disp_bcd,
        output state,
        output running,
        output frozen,
        output wrap_pulse
    );

endinterface

// File: rtl/stopwatch_bcd_digit_cnt.sv
// One BCD digit of the mm:ss count chain, modulo MAX+1.
// Carry is combinational so digits can be chained on one edge.
module bcd_digit_cnt #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] value,
    output logic       carry
);

    localparam logic [3:0] MAXV = 4'(MAX);

    // Digit register: clear wins, out-of-range values fold back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 4'd0;
        end else if (clr) begin
            value <= 4'd0;
        end else if (en) begin
            if (value >= MAXV) begin
                value <= 4'd0;
            end else begin
                value <= value + 4'd1;
            end
        end
    end

    assign carry = en && (value == MAXV);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: control FSM, mm:ss BCD chain, lap hold.
// Outputs are decoded from registers only.
module stopwatch_ctrl
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    stopwatch_if.slave bus
);

    sw_state_e   cur;
    sw_state_e   nxt;
    logic        cnt_en;
    logic        cnt_clr;
    logic        lap_load;
    logic [3:0]  so;
    logic [3:0]  st;
    logic [3:0]  mo;
    logic [3:0]  mt;
    logic        c_so;
    logic        c_st;
    logic        c_mo;
    logic        c_mt;
    logic [15:0] live;
    logic [15:0] lap_q;
    logic        wrap_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Next state; clear > start > lap among pulses valid here.
    always_comb begin
        nxt      = cur;
        cnt_clr  = 1'b0;
        lap_load = 1'b0;
        unique case (cur)
            IDLE: begin
                if (bus.start_pulse) begin
                    nxt = RUN;
                end
            end
            RUN: begin
                if (bus.start_pulse) begin
                    nxt = PAUSE;
                end else if (bus.lap_pulse) begin
                    nxt      = LAP;
                    lap_load = 1'b1;
                end
            end
            LAP: begin
                if (bus.start_pulse) begin
                    nxt = PAUSE;
                end else if (bus.lap_pulse) begin
                    nxt = RUN;
                end
            end
            PAUSE: begin
                if (bus.clear_pulse) begin
                    nxt     = IDLE;
                    cnt_clr = 1'b1;
                end else if (bus.start_pulse) begin
                    nxt = RUN;
                end
            end
        endcase
    end

    // Count enable follows the pre-edge state.
    assign cnt_en = bus.tick && is_counting(cur);

    bcd_digit_cnt #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .value (so),
        .carry (c_so)
    );

    bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (c_so),
        .value (st),
        .carry (c_st)
    );

    bcd_digit_cnt #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (c_st),
        .value (mo),
        .carry (c_mo)
    );

    bcd_digit_cnt #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (c_mo),
        .value (mt),
        .carry (c_mt)
    );

    assign live = {mt, mo, st, so};

    // Lap hold captures the pre-increment live count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q <= 16'h0000;
        end else if (cnt_clr) begin
            lap_q <= 16'h0000;
        end else if (lap_load) begin
            lap_q <= live;
        end
    end

    // Top-digit carry means 59:59 rolled over this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= c_mt;
        end
    end

    assign bus.disp_bcd   = (cur == LAP) ? lap_q : live;
    assign bus.state      = cur;
    assign bus.running    = is_counting(cur);
    assign bus.frozen     = (cur == LAP);
    assign bus.wrap_pulse = wrap_q;

endmodule
